// File: rtl/reaction_pkg.sv
// Shared types and helpers for the button-reaction scorer: FSM state
// encoding, 7-segment glyphs and saturating BCD arithmetic on a score
// of up to four digits (digit 0 in bits [3:0]).
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_MAX_DIGITS = 4;

    // Active-high segments, a = bit 0 ... g = bit 6
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        logic [6:0] glyph;
        case (digit)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
            default: glyph = SEG_OFF;
        endcase
        return glyph;
    endfunction

    // True when every used digit reads 9
    function automatic logic bcd_is_max(input logic [15:0] value, input int digits);
        logic is_max;
        is_max = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if ((i < digits) && (value[4*i +: 4] != 4'd9)) begin
                is_max = 1'b0;
            end else begin
                is_max = is_max;
            end
        end
        return is_max;
    endfunction

    // Add one with decimal carry; holds at all-nines
    function automatic logic [15:0] bcd_inc(input logic [15:0] value, input int digits);
        logic [15:0] result;
        logic        carry;
        result = value;
        carry  = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if ((i < digits) && carry) begin
                if (result[4*i +: 4] == 4'd9) begin
                    result[4*i +: 4] = 4'd0;
                end else begin
                    result[4*i +: 4] = result[4*i +: 4] + 4'd1;
                    carry            = 1'b0;
                end
            end else begin
                carry = carry;
            end
        end
        return bcd_is_max(value, digits) ? value : result;
    endfunction

    // Subtract one with decimal borrow; holds at zero
    function automatic logic [15:0] bcd_dec(input logic [15:0] value, input int digits);
        logic [15:0] result;
        logic        borrow;
        result = value;
        borrow = 1'b1;
        for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
            if ((i < digits) && borrow) begin
                if (result[4*i +: 4] == 4'd0) begin
                    result[4*i +: 4] = 4'd9;
                end else begin
                    result[4*i +: 4] = result[4*i +: 4] - 4'd1;
                    borrow           = 1'b0;
                end
            end else begin
                borrow = borrow;
            end
        end
        return (value == 16'h0000) ? value : result;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser on the inverted (active-high)
// button, a stability counter, the debounced level and a press pulse on
// its rising edge. Release edges produce nothing.
module debounce_channel
    import reaction_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button_n,
    output logic press
);

    localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_FLIP = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    logic          sync1_r;
    logic          sync2_r;
    logic          stable_r;
    logic          stable_d_r;
    logic [CW-1:0] cnt_r;

    // Synchronise, count disagreement and flip the stable level. The counter
    // reaching DEBOUNCE_CYCLES-1 is recognised one edge later, so the flip
    // lands once the count has run one step past that value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            cnt_r      <= '0;
        end else begin
            sync1_r    <= ~button_n;
            sync2_r    <= sync1_r;
            stable_d_r <= stable_r;
            if (sync2_r == stable_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_FLIP) begin
                stable_r <= sync2_r;
                cnt_r    <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end
        end
    end

    assign press = stable_r & ~stable_d_r;

endmodule

// File: rtl/reaction_scorer.sv
// Button-reaction game scorer: debounced presses are judged against a
// rotating one-hot target; hits add to a saturating BCD score, wrong
// presses optionally subtract, and each score digit drives a 7-seg display.
module reaction_scorer
    import reaction_pkg::*;
#(
    parameter int N_BUTTONS       = 3,
    parameter int SCORE_DIGITS    = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TARGET_PERIOD   = 1000,
    parameter int MISS_PENALTY    = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_BUTTONS-1:0]      button_n,
    input  logic                      enable,
    output logic [N_BUTTONS-1:0]      target,
    output logic [4*SCORE_DIGITS-1:0] score_bcd,
    output logic [7*SCORE_DIGITS-1:0] seg,
    output logic                      hit,
    output logic                      miss,
    output logic                      full
);

    localparam int                   SW           = 4 * SCORE_DIGITS;
    localparam int                   TW           = $clog2(TARGET_PERIOD);
    localparam logic [TW-1:0]        TIMER_RELOAD = TW'(TARGET_PERIOD - 1);
    localparam logic [TW-1:0]        TIMER_ONE    = TW'(1);
    localparam logic [N_BUTTONS-1:0] TARGET_FIRST = N_BUTTONS'(1);

    logic [N_BUTTONS-1:0] press_s;
    logic [N_BUTTONS-1:0] target_rot_s;
    logic                 press_any_s;
    logic                 press_on_target_s;
    logic [15:0]          score_inc_s;
    logic [15:0]          score_dec_s;
    logic                 score_inc_max_s;

    state_t               state_r;
    logic [N_BUTTONS-1:0] target_r;
    logic [TW-1:0]        timer_r;
    logic [15:0]          score_r;
    logic                 hit_r;
    logic                 miss_r;
    logic                 full_r;

    genvar g;
    generate
        for (g = 0; g < N_BUTTONS; g++) begin : g_db
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk      (clk),
                .reset    (reset),
                .button_n (button_n[g]),
                .press    (press_s[g])
            );
        end
    endgenerate

    // Press classification, target rotation and next score candidates
    always_comb begin
        target_rot_s      = {target_r[N_BUTTONS-2:0], target_r[N_BUTTONS-1]};
        press_any_s       = |press_s;
        press_on_target_s = (press_s == target_r);
        score_inc_s       = bcd_inc(score_r, SCORE_DIGITS);
        score_dec_s       = bcd_dec(score_r, SCORE_DIGITS);
        score_inc_max_s   = bcd_is_max(score_inc_s, SCORE_DIGITS);
    end

    // Game FSM with target, timer, score and pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            target_r <= '0;
            timer_r  <= TIMER_RELOAD;
            score_r  <= 16'h0000;
            hit_r    <= 1'b0;
            miss_r   <= 1'b0;
            full_r   <= 1'b0;
        end else begin
            hit_r  <= 1'b0;
            miss_r <= 1'b0;
            if (!enable) begin
                state_r  <= IDLE;
                target_r <= '0;
                timer_r  <= TIMER_RELOAD;
                full_r   <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        score_r  <= 16'h0000;
                        target_r <= TARGET_FIRST;
                        timer_r  <= TIMER_RELOAD;
                        full_r   <= 1'b0;
                        state_r  <= ARMED;
                    end
                    ARMED: begin
                        if (press_any_s && press_on_target_s) begin
                            hit_r   <= 1'b1;
                            score_r <= score_inc_s;
                            if (score_inc_max_s) begin
                                state_r  <= DONE;
                                target_r <= '0;
                                full_r   <= 1'b1;
                            end else begin
                                target_r <= target_rot_s;
                                timer_r  <= TIMER_RELOAD;
                            end
                        end else if (press_any_s) begin
                            // Target and timer are left exactly as they were
                            miss_r <= 1'b1;
                            if (MISS_PENALTY != 0) begin
                                score_r <= score_dec_s;
                            end else begin
                                score_r <= score_r;
                            end
                        end else if (timer_r == '0) begin
                            target_r <= target_rot_s;
                            timer_r  <= TIMER_RELOAD;
                        end else begin
                            timer_r <= timer_r - TIMER_ONE;
                        end
                    end
                    DONE: begin
                        target_r <= '0;
                        full_r   <= 1'b1;
                    end
                    default: begin
                        state_r  <= IDLE;
                        target_r <= '0;
                        full_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    generate
        for (g = 0; g < SCORE_DIGITS; g++) begin : g_seg
            assign seg[7*g +: 7] = bcd_to_seg(score_r[4*g +: 4]);
        end
        if (SW < 16) begin : g_pad
            // Digits above SCORE_DIGITS are never touched and stay zero
            logic unused_pad_s;
            assign unused_pad_s = ^score_r[15:SW];
        end
    endgenerate

    assign target    = target_r;
    assign score_bcd = score_r[SW-1:0];
    assign hit       = hit_r;
    assign miss      = miss_r;
    assign full      = full_r;

endmodule

// File: tb/tb_reaction_scorer.sv
// Directed bench for reaction_scorer: one instance with default parameters
// for scoring/debounce behaviour, one with TARGET_PERIOD=8 for the timeout.
module tb_reaction_scorer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        enable_t;
    logic [2:0]  button_n;
    logic [2:0]  button_t_n;

    logic [2:0]  target, target_t;
    logic [7:0]  score_bcd, score_t;
    logic [13:0] seg, seg_t;
    logic        hit, miss, full;
    logic        hit_t, miss_t, full_t;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    reaction_scorer u_dut (
        .clk       (clk),
        .reset     (reset),
        .button_n  (button_n),
        .enable    (enable),
        .target    (target),
        .score_bcd (score_bcd),
        .seg       (seg),
        .hit       (hit),
        .miss      (miss),
        .full      (full)
    );

    reaction_scorer #(.TARGET_PERIOD(8)) u_dut_t (
        .clk       (clk),
        .reset     (reset),
        .button_n  (button_t_n),
        .enable    (enable_t),
        .target    (target_t),
        .score_bcd (score_t),
        .seg       (seg_t),
        .hit       (hit_t),
        .miss      (miss_t),
        .full      (full_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold the masked buttons low for 'hold' cycles, release, let the release
    // settle; count hit/miss pulses and the first pulse offset after edge k.
    task automatic do_press(input logic [2:0] mask, input int hold,
                            output int hits, output int misses, output int first_j);
        hits = 0; misses = 0; first_j = -1;
        @(negedge clk);
        button_n = ~mask;
        for (int j = 0; j < hold; j++) begin
            @(negedge clk);
            if (hit === 1'b1)  begin hits++;   if (first_j < 0) first_j = j; end
            if (miss === 1'b1) begin misses++; if (first_j < 0) first_j = j; end
        end
        @(negedge clk);
        button_n = 3'b111;
        for (int j = 0; j < 24; j++) begin
            @(negedge clk);
            if (hit === 1'b1)  hits++;
            if (miss === 1'b1) misses++;
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int j = 0; j < cycles; j++) begin
            @(negedge clk);
            if (hit === 1'b1 || miss === 1'b1) pulses++;
        end
    endtask

    int          h, m, f, p, tot_h, tot_m;
    logic [2:0]  tgt_exp;

    initial begin
        reset = 1'b1; enable = 1'b0; enable_t = 1'b0;
        button_n = 3'b111; button_t_n = 3'b111;
        repeat (3) @(negedge clk);
        check("rst_target", target, 3'b000);
        check("rst_score",  score_bcd, 8'h00);
        check("rst_seg",    seg, 14'h1FBF);
        check("rst_hit",    hit, 1'b0);
        check("rst_miss",   miss, 1'b0);
        check("rst_full",   full, 1'b0);
        check("rst_target_t", target_t, 3'b000);

        // Timeout rotation every 8 cycles with no presses
        reset = 1'b0;
        enable_t = 1'b1;
        for (int j = 0; j < 25; j++) begin
            @(negedge clk);
            check($sformatf("timeout_j%0d", j), target_t, 3'b001 << ((j / 8) % 3));
        end
        check("timeout_score", score_t, 8'h00);

        // Start main game
        enable = 1'b1;
        @(negedge clk);
        check("start_target", target, 3'b001);
        check("start_score",  score_bcd, 8'h00);

        // First hit and its latency
        do_press(3'b001, 25, h, m, f);
        check("hit1_count",  h, 1);
        check("hit1_miss",   m, 0);
        check("hit1_latency", f, 19);
        check("hit1_score",  score_bcd, 8'h01);
        check("hit1_target", target, 3'b010);
        check("hit1_seg",    seg, 14'h1F86);

        // Short glitch on the target channel
        @(negedge clk);
        button_n = 3'b101;
        repeat (5) @(negedge clk);
        button_n = 3'b111;
        count_pulses(30, p);
        check("glitch_pulses", p, 0);
        check("glitch_target", target, 3'b010);
        check("glitch_score",  score_bcd, 8'h01);

        // Four hits to reach 05
        tgt_exp = 3'b010; tot_h = 0; tot_m = 0;
        for (int i = 0; i < 4; i++) begin
            do_press(tgt_exp, 25, h, m, f);
            tot_h += h; tot_m += m;
            tgt_exp = {tgt_exp[1:0], tgt_exp[2]};
        end
        check("to5_hits",   tot_h, 4);
        check("to5_score",  score_bcd, 8'h05);
        check("to5_target", target, 3'b100);

        // Wrong press with penalty
        do_press(3'b001, 25, h, m, f);
        check("miss_pulse",  m, 1);
        check("miss_nohit",  h, 0);
        check("miss_score",  score_bcd, 8'h04);
        check("miss_target", target, 3'b100);

        // Drain to zero, then a miss at zero stays zero
        for (int i = 0; i < 4; i++) do_press(3'b010, 25, h, m, f);
        check("drain_score", score_bcd, 8'h00);
        do_press(3'b001, 25, h, m, f);
        check("miss0_pulse", m, 1);
        check("miss0_score", score_bcd, 8'h00);

        // Target plus another channel together is a miss only
        do_press(3'b101, 25, h, m, f);
        check("simul_miss",   m, 1);
        check("simul_nohit",  h, 0);
        check("simul_score",  score_bcd, 8'h00);
        check("simul_target", target, 3'b100);

        // Preload 98 hits
        tgt_exp = 3'b100; tot_h = 0; tot_m = 0;
        for (int i = 0; i < 98; i++) begin
            do_press(tgt_exp, 25, h, m, f);
            tot_h += h; tot_m += m;
            tgt_exp = {tgt_exp[1:0], tgt_exp[2]};
        end
        check("pre_hits",   tot_h, 98);
        check("pre_misses", tot_m, 0);
        check("pre_score",  score_bcd, 8'h98);
        check("pre_seg",    seg, 14'h37FF);
        check("pre_target", target, tgt_exp);
        check("pre_full",   full, 1'b0);

        // Final hit saturates
        do_press(tgt_exp, 25, h, m, f);
        check("sat_hit",    h, 1);
        check("sat_score",  score_bcd, 8'h99);
        check("sat_full",   full, 1'b1);
        check("sat_target", target, 3'b000);
        do_press(3'b001, 25, h, m, f);
        check("done_ignore", h + m, 0);
        check("done_score",  score_bcd, 8'h99);

        // Disable, then restart
        enable = 1'b0;
        @(negedge clk);
        check("off_full",   full, 1'b0);
        check("off_score",  score_bcd, 8'h99);
        enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("restart_score",  score_bcd, 8'h00);
        check("restart_target", target, 3'b001);

        // Reset in the middle of a debounce
        button_n = 3'b110;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        button_n = 3'b111;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        count_pulses(40, p);
        check("rstmid_pulses", p, 0);
        check("rstmid_target", target, 3'b001);
        check("rstmid_score",  score_bcd, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reaction_scorer.md
# reaction_scorer

Parametrised button-reaction scoring block for the button game on the board. It debounces N active-low push-buttons and presents a rotating one-hot target. It keeps a saturating multi-digit BCD score (hit adds 1, optional penalty on a wrong press) and drives one 7-segment digit per score digit. It replaces the fixed three-button, single-counter score path with a configurable channel count, digit count, debounce length, target timeout and miss mode.

## Interface
- N_BUTTONS, 3: button/target channel count, 2..8
- SCORE_DIGITS, 2: BCD digits of score, 1..4
- DEBOUNCE_CYCLES, 16: consecutive stable cycles before a level change is accepted, ≥2
- TARGET_PERIOD, 1000: cycles a target stays lit before timing out, ≥2
- MISS_PENALTY, 1: 1 = wrong press subtracts 1 (saturating at 0); 0 = wrong press ignored

- clk  in  1  single system clock
- reset  in  1  synchronous, active-high
- button_n  in  N_BUTTONS  raw active-low buttons, asynchronous to clk
- enable  in  1  level; high = run game, low = return to IDLE
- target  out  N_BUTTONS  one-hot lit channel; all-zero outside ARMED
- score_bcd  out  4*SCORE_DIGITS  score, digit 0 in bits [3:0]
- seg  out  7*SCORE_DIGITS  active-high segments a..g per digit; digit i in [7i+6:7i], a = LSB
- hit  out  1  one-cycle pulse on a correct press
- miss  out  1  one-cycle pulse on a wrong press (pulses even when MISS_PENALTY=0)
- full  out  1  level; score saturated at all-nines (DONE state)

## Operation
- Per channel: 2-flop synchroniser on ~button_n. Counter clears while synced == stable and increments while they differ. When the counter reaches DEBOUNCE_CYCLES-1 and the inputs still differ, stable flips on the next edge and the counter clears. press[i] = stable[i] & ~stable_d[i]. Release edges are ignored.
- FSM states: IDLE, ARMED, DONE.
  - IDLE: target=0. On enable=1: score cleared to 0, target=1 (channel 0), timer loaded, go to ARMED.
  - ARMED:
    - Any press with press == target (exactly one bit, on target): hit. Score +1 in BCD with carry across digits. Target rotates left (MSB wraps to bit 0). Timer reloads.
    - Any press with a non-target bit set, including simultaneous target + other: miss. Score −1 if MISS_PENALTY, floored at 0. Target and timer unchanged.
    - No press and timer expires after TARGET_PERIOD cycles: target rotates, timer reloads, score unchanged, no pulse.
    - Hit taking score to all-nines: go to DONE.
  - DONE: target=0, full=1, presses ignored, score held. enable=0 → IDLE.
- enable=0 in any state → IDLE next edge. Score is held until the next start or reset.
- seg is decoded combinationally from score_bcd. BCD digit 0–9 uses standard glyphs. Segments are all-off for any non-BCD code, which cannot occur.

## Timing
- Reset values: state IDLE, target 0, score_bcd 0, seg = "0" glyph on every digit (7'h3F), hit 0, miss 0, full 0, debounce stable 0 (released), counters 0, synchronisers 0.
- Latency: button_n first sampled low at edge k and held → stable flips at edge k+2+DEBOUNCE_CYCLES. hit/miss and score_bcd/seg update at edge k+3+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES synced cycles produces no press.
- Timer timeout: target changes exactly TARGET_PERIOD cycles after the edge that loaded it.
- A hit and a timeout in the same cycle count as a hit; the timer reloads once.
- Reset mid-game overrides everything in the same edge.

## Structure
- Shared package `reaction_pkg` holds:
  - state enum {IDLE, ARMED, DONE}
  - 7-seg glyph constants and `bcd_to_seg` function
  - BCD increment/decrement-with-saturation functions
- One sub-module: `debounce_channel` (synchroniser, counter, stable, press output), instantiated N_BUTTONS times via generate.
- Top holds the FSM, the target rotator, the timer and the score registers.

## Test plan
- Reset held 3 cycles → target=0, score_bcd=8'h00, seg=14'h1FBF, hit=miss=full=0.
- enable=1, press channel 0 held 40 cycles, DEBOUNCE_CYCLES=16 → hit pulses once at edge k+19, score_bcd=8'h01, target 001→010.
- Defaults, target=010, 5-cycle low glitch on channel 1 → no hit. Then button 0 pressed with score 8'h05 → miss pulse, score 8'h04, target still 010. Repeat at score 0 → stays 8'h00.
- TARGET_PERIOD=8, no presses → target 001→010→100→001 every 8 cycles; score unchanged.
- Preload by 98 hits → score 8'h98. One hit → 8'h99, full=1, target=0, further presses ignored. enable=0 then 1 → score 8'h00, target 001.
- Simultaneous press of target and non-target channel → miss only. Reset asserted mid-debounce → no press is later emitted.
